// File: rtl/hex_entry.sv
// hex_entry: turns debounced push-button levels into edits of a 32-bit hex word.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset, released synchronously upstream
//   btn_left     move cursor one digit toward digit 7 (7 wraps to 0)
//   btn_right    move cursor one digit toward digit 0 (0 wraps to 7)
//   btn_up       increment nibble under cursor, modulo 16
//   btn_down     decrement nibble under cursor, modulo 16
//   btn_load     copy the edit word to value, pulse value_valid
//   btn_clr      clear the edit word and the cursor
//   num          edit word, feeds the seven-segment multiplexer
//   value        committed word
//   value_valid  one-cycle pulse when value is updated
//   cursor       index of the nibble being edited (0 = num[3:0])
//
// Build option: define AUTO_REPEAT_EN to add hold-to-repeat on btn_up/btn_down.
module hex_entry #(
    parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_load,
    input  logic        btn_clr,
    output logic [31:0] num,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [2:0]  cursor
);

    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_cfg
        $error("hex_entry: REPEAT_DELAY and REPEAT_RATE must be non-zero");
    end

    // Bit order: {clr, load, down, up, right, left}
    logic [5:0] btn_raw;
    logic [5:0] sync1_q, sync2_q, prev_q;
    logic [5:0] btn_edge;

    assign btn_raw = {btn_clr, btn_load, btn_down, btn_up, btn_right, btn_left};

    // Reset to 1 so a button held through reset must be released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_edge = sync2_q & ~prev_q;

    logic rep_step;
    logic rep_up;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} rep_state_e;

    rep_state_e      rep_q, rep_d;
    logic            dir_up_q, dir_up_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_lim;
    logic            hi_pri, held, opposite;

    // Any edge that owns the cycle ahead of up/down.
    assign hi_pri   = btn_edge[5] | btn_edge[4] | btn_edge[1] | btn_edge[0];
    assign held     = dir_up_q ? sync2_q[2] : sync2_q[3];
    assign opposite = dir_up_q ? sync2_q[3] : sync2_q[2];
    assign cnt_lim  = (rep_q == StHold) ? CntW'(REPEAT_DELAY - 1) : CntW'(REPEAT_RATE - 1);

    always_comb begin
        rep_d    = rep_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        rep_step = 1'b0;
        unique case (rep_q)
            StIdle: begin
                // Arm only when the edge step itself was applied.
                if (!hi_pri && (btn_edge[2] ^ btn_edge[3])) begin
                    rep_d    = StHold;
                    dir_up_d = btn_edge[2];
                    cnt_d    = '0;
                end
            end
            StHold, StRepeat: begin
                if (!held || opposite || btn_edge[5]) begin
                    rep_d = StIdle;
                    cnt_d = '0;
                end else if (cnt_q == cnt_lim) begin
                    // Step may be dropped by a higher-priority edge; counter clears regardless.
                    rep_step = 1'b1;
                    cnt_d    = '0;
                    rep_d    = StRepeat;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                rep_d = StIdle;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q    <= StIdle;
            dir_up_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rep_q    <= rep_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rep_up = dir_up_q;
`else
    assign rep_step = 1'b0;
    assign rep_up   = 1'b0;
`endif

    logic [31:0] num_q, num_d;
    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic [2:0]  cursor_q, cursor_d;
    logic [3:0]  nib;

    // One action per cycle; lower-priority edges in the same cycle are discarded.
    always_comb begin
        num_d    = num_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        cursor_d = cursor_q;
        nib      = num_q[{cursor_q, 2'b00} +: 4];
        if (btn_edge[5]) begin
            num_d    = '0;
            cursor_d = '0;
        end else if (btn_edge[4]) begin
            value_d = num_q;
            valid_d = 1'b1;
        end else if (btn_edge[0] | btn_edge[1]) begin
            if (btn_edge[0] && !btn_edge[1]) begin
                cursor_d = cursor_q + 3'd1;
            end else if (btn_edge[1] && !btn_edge[0]) begin
                cursor_d = cursor_q - 3'd1;
            end
        end else if (btn_edge[2] | btn_edge[3]) begin
            if (btn_edge[2] && !btn_edge[3]) begin
                num_d[{cursor_q, 2'b00} +: 4] = nib + 4'd1;
            end else if (btn_edge[3] && !btn_edge[2]) begin
                num_d[{cursor_q, 2'b00} +: 4] = nib - 4'd1;
            end
        end else if (rep_step) begin
            num_d[{cursor_q, 2'b00} +: 4] = rep_up ? nib + 4'd1 : nib - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q    <= INIT_VALUE;
            value_q  <= INIT_VALUE;
            valid_q  <= 1'b0;
            cursor_q <= '0;
        end else begin
            num_q    <= num_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            cursor_q <= cursor_d;
        end
    end

    assign num         = num_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign cursor      = cursor_q;

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: a behavioural model pushes the expected
// num/value/cursor and load-pulse count per button action; they are popped and
// compared once the action has had time to propagate.
module tb_hex_entry;

    localparam logic [31:0] Init     = 32'h1234_5678;
    localparam int          RepDelay = 10;
    localparam int          RepRate  = 4;

    localparam logic [5:0] BLeft  = 6'b000001;
    localparam logic [5:0] BRight = 6'b000010;
    localparam logic [5:0] BUp    = 6'b000100;
    localparam logic [5:0] BDown  = 6'b001000;
    localparam logic [5:0] BLoad  = 6'b010000;
    localparam logic [5:0] BClr   = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  btn = '0;
    logic [31:0] num, value;
    logic        value_valid;
    logic [2:0]  cursor;

    hex_entry #(
        .INIT_VALUE  (Init),
        .REPEAT_DELAY(RepDelay),
        .REPEAT_RATE (RepRate)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_left   (btn[0]),
        .btn_right  (btn[1]),
        .btn_up     (btn[2]),
        .btn_down   (btn[3]),
        .btn_load   (btn[4]),
        .btn_clr    (btn[5]),
        .num        (num),
        .value      (value),
        .value_valid(value_valid),
        .cursor     (cursor)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] num;
        logic [31:0] val;
        logic [2:0]  cur;
        int          pulses;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;

    logic [31:0] m_num, m_val;
    logic [2:0]  m_cur;

    always @(negedge clk) begin
        if (rst_n && value_valid) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_num = Init;
        m_val = Init;
        m_cur = '0;
    endtask

    // Expected effect of all bits in m rising together and held for hold samples.
    task automatic model(input logic [5:0] m, input int hold);
        int         steps;
        logic [3:0] nb;
        if (m[5]) begin
            m_num = '0;
            m_cur = '0;
        end else if (m[4]) begin
            m_val = m_num;
        end else if (m[0] || m[1]) begin
            if (m[0] && !m[1]) m_cur = m_cur + 3'd1;
            else if (m[1] && !m[0]) m_cur = m_cur - 3'd1;
        end else if (m[2] ^ m[3]) begin
            steps = 1;
`ifdef AUTO_REPEAT_EN
            if (hold >= RepDelay + 1) steps = steps + 1 + (hold - RepDelay - 1) / RepRate;
`endif
            nb = m_num[int'(m_cur) * 4 +: 4];
            nb = m[2] ? nb + 4'(steps) : nb - 4'(steps);
            m_num[int'(m_cur) * 4 +: 4] = nb;
        end
    endtask

    task automatic push_exp(input string tag, input int pulses);
        exp_t e;
        e.tag    = tag;
        e.num    = m_num;
        e.val    = m_val;
        e.cur    = m_cur;
        e.pulses = pulses;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int pulses_seen);
        exp_t e;
        e = sb.pop_front();
        check_eq({e.tag, "_num"}, num, e.num);
        check_eq({e.tag, "_value"}, value, e.val);
        check_eq({e.tag, "_cursor"}, {29'd0, cursor}, {29'd0, e.cur});
        check_eq({e.tag, "_pulses"}, pulses_seen, e.pulses);
    endtask

    task automatic press(input string tag, input logic [5:0] mask, input int hold);
        int v0;
        model(mask, hold);
        push_exp(tag, (mask[4] && !mask[5]) ? 1 : 0);
        v0 = valid_cnt;
        btn = mask;
        repeat (hold) tick();
        btn = '0;
        repeat (6) tick();
        pop_cmp(valid_cnt - v0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int v0;
        model_reset();
        repeat (3) tick();
        check_eq("rst_num", num, Init);
        check_eq("rst_value", value, Init);
        check_eq("rst_cursor", {29'd0, cursor}, 32'd0);
        check_eq("rst_valid", {31'd0, value_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        press("load", BLoad, 2);

        press("clr", BClr, 1);
        press("down_wrap", BDown, 1);
        for (int i = 0; i < 8; i++) press("left", BLeft, 1);
        press("right_wrap", BRight, 1);
        press("up_d7", BUp, 1);

        // 0x000000FF with cursor 0, then increment without carry
        press("clr2", BClr, 1);
        press("down0", BDown, 1);
        press("left1", BLeft, 1);
        press("down1", BDown, 1);
        press("right0", BRight, 1);
        press("up_nocarry", BUp, 1);

        // Build 0xABCD0000
        press("clr3", BClr, 1);
        repeat (4) press("left_to4", BLeft, 1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) press("left_next", BLeft, 1);
            repeat (3 + d) press("down_build", BDown, 1);
        end
        press("clr_load", BClr | BLoad, 1);
        press("down_a", BDown, 1);
        press("up_down", BUp | BDown, 1);
        press("left_right", BLeft | BRight, 1);
        press("load2", BLoad, 1);
        press("clr_left", BClr | BLeft, 1);

        // Held up/down: one step, or auto-repeat when built with it
        press("up_hold", BUp, 31);
        repeat (20) tick();
        push_exp("up_hold_idle", 0);
        pop_cmp(0);

        // Button held through reset gives no action
        rst_n = 1'b0;
        btn   = BUp;
        repeat (3) tick();
        model_reset();
        rst_n = 1'b1;
        repeat (10) tick();
        btn = '0;
        v0  = valid_cnt;
        repeat (6) tick();
        push_exp("rst_held", 0);
        pop_cmp(valid_cnt - v0);
        press("up_after_rst", BUp, 1);
        press("left_after_rst", BLeft, 1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_num", num, Init);
        check_eq("async_value", value, Init);
        check_eq("async_cursor", {29'd0, cursor}, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        press("down_post", BDown, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
